pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller: sequences an instruction through FETCH, DECODE,
// EXECUTE and WRITEBACK, with a halt/resume handshake, a sticky fetch-timeout
// fault and a count of retired instructions.
// Optional feature: define PIPELINE_CONTROLLER_SINGLE_STEP_EN to add the
// step_mode input, which parks the pipeline in HALTED after every instruction.
module pipeline_controller #(
  parameter logic [7:0]  HALT_OP       = 8'hFF,
  parameter logic [7:0]  NOP_OP        = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_program,
  input  logic        resume,
  input  logic        mem_ack,
`ifdef PIPELINE_CONTROLLER_SINGLE_STEP_EN
  input  logic        step_mode,
`endif
  input  logic [7:0]  OP_code,
  output logic        mem_req,
  output logic        ir_load,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_inc,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALTED    = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Value of the timeout counter in the last FETCH cycle allowed without ack.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        pend_q, pend_d;
  logic [15:0] retire_q, retire_d;
  logic        op_halt_q, op_halt_d;
  logic        op_nop_q, op_nop_d;
  // Low only for the cycle between reset release and the first clock edge,
  // so mem_req stays quiet while rst is (or has just been) asserted.
  logic        run_q;
  logic        step_w;
  logic        park_w;

`ifdef PIPELINE_CONTROLLER_SINGLE_STEP_EN
  assign step_w = step_mode;
`else
  assign step_w = 1'b0;
`endif

  // An instruction completion parks in HALTED when a halt is pending, being
  // requested right now, or single-step is active.
  assign park_w = pend_q | halt_program | step_w;

  // Next-state, timeout, pending-halt and retire-count logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pend_d    = pend_q;
    retire_d  = retire_q;
    op_halt_d = op_halt_q;
    op_nop_d  = op_nop_q;

    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          if (mem_ack)                state_d = ST_DECODE;
          else if (tmo_q == TMO_LAST) state_d = ST_FAULT;
          else if (halt_program)      state_d = ST_HALTED;
          else                        tmo_d   = tmo_q + 8'd1;
        end
      end
      ST_DECODE: begin
        // Classify the opcode here so EXECUTE outputs come from registers.
        op_halt_d = (OP_code == HALT_OP);
        op_nop_d  = (OP_code == NOP_OP);
        state_d   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        retire_d = retire_q + 16'd1;
        if (op_halt_q)     state_d = ST_HALTED;
        else if (op_nop_q) state_d = park_w ? ST_HALTED : ST_FETCH;
        else               state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = park_w ? ST_HALTED : ST_FETCH;
      ST_HALTED: begin
        if (resume && !halt_program) state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // The timeout window restarts on every entry to FETCH.
    if (state_d == ST_FETCH && state_q != ST_FETCH) tmo_d = 8'd0;

    // A halt requested mid-instruction waits for the instruction to finish.
    if (halt_program &&
        (state_q inside {ST_DECODE, ST_EXECUTE, ST_WRITEBACK})) pend_d = 1'b1;
    if (state_d == ST_HALTED) pend_d = 1'b0;
  end

  // State and flag registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      tmo_q     <= 8'd0;
      pend_q    <= 1'b0;
      retire_q  <= 16'd0;
      op_halt_q <= 1'b0;
      op_nop_q  <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      retire_q  <= retire_d;
      op_halt_q <= op_halt_d;
      op_nop_q  <= op_nop_d;
      run_q     <= 1'b1;
    end
  end

  // Output decode from registered state; only ir_load follows mem_ack directly.
  always_comb begin
    mem_req    = run_q && (state_q == ST_FETCH);
    ir_load    = mem_req && mem_ack;
    decode_en  = (state_q == ST_DECODE);
    exec_en    = (state_q == ST_EXECUTE);
    wb_en      = (state_q == ST_WRITEBACK);
    pc_inc     = ((state_q == ST_EXECUTE) && op_nop_q && !op_halt_q) ||
                 (state_q == ST_WRITEBACK);
    halted     = (state_q == ST_HALTED);
    fault      = (state_q == ST_FAULT);
    state      = state_q;
    retire_cnt = retire_q;
  end

endmodule
